// File: rtl/ram_dp_clr.sv
// ram_dp_clr: single-clock dual-port RAM with read-during-write policy, gated output and a sweep-clear engine
module ram_dp_clr #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter logic [DW-1:0] CLEAR_VAL = '0,
    parameter bit RDW_NEW = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] i,
    input  logic          r,
    input  logic          w,
    input  logic          oe,
    input  logic          clr,
    output logic [DW-1:0] o,
    output logic          busy
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t st;
    logic [AW-1:0] cnt;
    logic [DW-1:0] d;
    logic [DW-1:0] ram [2**AW];
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    assign busy  = st == CLEAR;
    assign we    = !reset && (busy || w);
    assign waddr = busy ? cnt : wa;
    assign wdata = busy ? CLEAR_VAL : i;
    assign o     = oe ? d : '0;
    always_ff @(posedge clk)
        if (we) ram[waddr] <= wdata;
    // Sweep owns the array and d while busy; user strobes only act in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= CLEAR;
            cnt <= '0;
            d   <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            d   <= '0;
            if (cnt == '1) st <= IDLE;
        end else begin
            if (clr) begin
                st  <= CLEAR;
                cnt <= '0;
            end
            if (r) d <= (RDW_NEW && w && ra == wa) ? i : ram[ra];
        end
    end
endmodule
